// File: rtl/blend_pkg.sv
// Shared definitions for the two-image alpha blender: mode encodings,
// reset configuration and the lane product width.
package blend_pkg;

    localparam logic BLEND_MODE_INDEP = 1'b0;
    localparam logic BLEND_MODE_COMPL = 1'b1;

    // Reset configuration is a complementary 50/50 blend.
    localparam logic BLEND_RST_MODE = BLEND_MODE_COMPL;

    // Reset weight: one half of full scale (2^(w_w-1)).
    function automatic int unsigned blend_rst_weight(input int unsigned w_w);
        return 32'd1 << (w_w - 32'd1);
    endfunction

    // Full-precision pixel * (W_W+1)-bit weight product width.
    function automatic int unsigned blend_prod_w(input int unsigned data_w, input int unsigned w_w);
        return data_w + w_w + 32'd1;
    endfunction

endpackage

// File: rtl/image_blend_stream_if.sv
// Pixel-pair input stream and blended output stream of image_blend_stream.
interface image_blend_stream_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_pix_a;
    logic [DATA_W-1:0] s_pix_b;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    // The blender is the slave of the pixel-pair stream and drives the output.
    modport slave (
        input  s_valid, s_pix_a, s_pix_b, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_pix_a, s_pix_b, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/blend_lane.sv
// One blend lane: registers (pix * w) >> W_W when enabled. The multiplier
// expression is isolated here so an approximate multiplier can replace it.
module blend_lane
    import blend_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned W_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] pix,
    input  logic [W_W:0]      w,
    output logic [DATA_W-1:0] prod
);
    localparam int unsigned PROD_W = blend_prod_w(DATA_W, W_W);

    logic [PROD_W-1:0] full_c;

    assign full_c = PROD_W'(pix) * PROD_W'(w);

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else if (en) begin
            prod <= DATA_W'(full_c >> W_W);
        end
    end
endmodule

// File: rtl/image_blend_stream.sv
// Streaming two-image alpha blender with per-frame weight commit and backpressure.
// Define BLEND_SATURATE_EN to clamp overflowing sums instead of wrapping them.
module image_blend_stream
    import blend_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned W_W          = 8,
    parameter int unsigned FRAME_PIXELS = 90000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic                  cfg_mode,
    input  logic [W_W-1:0]        cfg_wa,
    input  logic [W_W-1:0]        cfg_wb,
    image_blend_stream_if.slave   bus,
    output logic                  frame_done
);
    localparam int unsigned      WA_W     = W_W + 1;
    localparam int unsigned      CNT_W    = $clog2(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [WA_W-1:0]  W_ONE    = WA_W'(1) << W_W;
    localparam logic [W_W-1:0]   W_RST    = W_W'(blend_rst_weight(W_W));

    logic             sh_mode;
    logic [W_W-1:0]   sh_wa;
    logic [W_W-1:0]   sh_wb;
    logic [WA_W-1:0]  act_wa;
    logic [WA_W-1:0]  act_wb;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             v1;
    logic             v2;
    logic [DATA_W-1:0] data2;

    logic              adv;
    logic              in_acc;
    logic              out_acc;
    logic              frame_start;
    logic [WA_W-1:0]   cmt_wa;
    logic [WA_W-1:0]   cmt_wb;
    logic [WA_W-1:0]   eff_wa;
    logic [WA_W-1:0]   eff_wb;
    logic [DATA_W-1:0] prod_a;
    logic [DATA_W-1:0] prod_b;
    logic [DATA_W-1:0] sum_c;

    // Handshake and weight selection; pixel 0 of a frame uses the weights it commits.
    always_comb begin
        adv         = !v2 || bus.m_ready;
        in_acc      = bus.s_valid && adv;
        out_acc     = v2 && bus.m_ready;
        frame_start = (in_cnt == '0);
        cmt_wa      = {1'b0, sh_wa};
        cmt_wb      = (sh_mode == BLEND_MODE_INDEP) ? {1'b0, sh_wb} : W_ONE - cmt_wa;
        eff_wa      = frame_start ? cmt_wa : act_wa;
        eff_wb      = frame_start ? cmt_wb : act_wb;
    end

    // Shadow config is always writable; active weights change only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode <= BLEND_RST_MODE;
            sh_wa   <= W_RST;
            sh_wb   <= W_RST;
            act_wa  <= {1'b0, W_RST};
            act_wb  <= {1'b0, W_RST};
        end else begin
            if (in_acc && frame_start) begin
                act_wa <= cmt_wa;
                act_wb <= cmt_wb;
            end
            if (cfg_load) begin
                sh_mode <= cfg_mode;
                sh_wa   <= cfg_wa;
                sh_wb   <= cfg_wb;
            end
        end
    end

    blend_lane #(.DATA_W(DATA_W), .W_W(W_W)) u_lane_a (
        .clk  (clk),
        .rst  (rst),
        .en   (in_acc),
        .pix  (bus.s_pix_a),
        .w    (eff_wa),
        .prod (prod_a)
    );

    blend_lane #(.DATA_W(DATA_W), .W_W(W_W)) u_lane_b (
        .clk  (clk),
        .rst  (rst),
        .en   (in_acc),
        .pix  (bus.s_pix_b),
        .w    (eff_wb),
        .prod (prod_b)
    );

`ifdef BLEND_SATURATE_EN
    logic [DATA_W:0] sum_wide_c;
    assign sum_wide_c = {1'b0, prod_a} + {1'b0, prod_b};
    assign sum_c      = sum_wide_c[DATA_W] ? '1 : sum_wide_c[DATA_W-1:0];
`else
    assign sum_c = prod_a + prod_b;
`endif

    // Pipeline valids and the output data register; everything freezes while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            data2 <= '0;
        end else if (adv) begin
            v1 <= in_acc;
            v2 <= v1;
            if (v1) begin
                data2 <= sum_c;
            end
        end
    end

    // Frame position counters on both sides of the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (in_acc) begin
                in_cnt <= (in_cnt == CNT_LAST) ? '0 : in_cnt + CNT_W'(1);
            end
            if (out_acc) begin
                out_cnt <= (out_cnt == CNT_LAST) ? '0 : out_cnt + CNT_W'(1);
            end
            frame_done <= out_acc && (out_cnt == CNT_LAST);
        end
    end

    assign bus.s_ready = adv;
    assign bus.m_valid = v2;
    assign bus.m_data  = data2;
    assign bus.m_last  = v2 && (out_cnt == CNT_LAST);
endmodule

// File: tb/tb_image_blend_stream.sv
// Directed and randomized bench for image_blend_stream against a frame-level
// reference model of the blend arithmetic and per-frame weight commit.
module tb_image_blend_stream;
    localparam int unsigned DW = 8;
    localparam int unsigned WW = 8;
    localparam int unsigned FP = 4;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_load = 1'b0;
    logic           cfg_mode = 1'b0;
    logic [WW-1:0]  cfg_wa = '0;
    logic [WW-1:0]  cfg_wb = '0;
    logic           frame_done;

    image_blend_stream_if #(.DATA_W(DW)) bus ();

    image_blend_stream #(.DATA_W(DW), .W_W(WW), .FRAME_PIXELS(FP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_wa     (cfg_wa),
        .cfg_wb     (cfg_wb),
        .bus        (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_checks = 0;
    exp_t exp_q[$];
    int   outs[$];
    int   sh_mode, sh_wa, sh_wb, act_wa, act_wb, in_idx;
    bit   rst_prev = 1'b1;
    bit   prev_stall = 1'b0;
    bit   exp_fd = 1'b0;
    bit   last_acc = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int   cyc = 0, acc_cyc = 0, out_cyc = 0;
    int   last_out = 0;
    int   n_last = 0, n_fd = 0, n_sready_low = 0, n_in = 0, n_out = 0, snap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int ref_blend(input int a, input int b, input int wa, input int wb);
        int s;
        s = (a * wa) / (1 << WW) + (b * wb) / (1 << WW);
`ifdef BLEND_SATURATE_EN
        if (s > (1 << DW) - 1) s = (1 << DW) - 1;
`else
        s = s % (1 << DW);
`endif
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        in_idx     = 0;
        sh_mode    = 1;
        sh_wa      = 1 << (WW - 1);
        sh_wb      = 1 << (WW - 1);
        act_wa     = 1 << (WW - 1);
        act_wb     = 1 << (WW - 1);
        exp_fd     = 1'b0;
        prev_stall = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model to the next rising edge.
    task automatic tick();
        bit in_acc, out_acc;
        @(negedge clk);
        if (rst_prev) begin
            chk("rst_s_ready", 32'(bus.s_ready), 1);
            chk("rst_m_valid", 32'(bus.m_valid), 0);
            chk("rst_m_data", 32'(bus.m_data), 0);
            chk("rst_m_last", 32'(bus.m_last), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
        end else begin
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 32'(bus.m_valid), 0);
                end else begin
                    chk("m_data", 32'(bus.m_data), 32'(exp_q[0].data));
                    chk("m_last", 32'(bus.m_last), 32'(exp_q[0].last));
                end
            end
            if (prev_stall) begin
                chk("stall_m_valid", 32'(bus.m_valid), 1);
                chk("stall_m_data", 32'(bus.m_data), 32'(prev_data));
                chk("stall_m_last", 32'(bus.m_last), 32'(prev_last));
            end
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
        end
        if (frame_done) n_fd++;
        if (!bus.s_ready) n_sready_low++;
        in_acc   = bus.s_valid && bus.s_ready && !rst;
        out_acc  = bus.m_valid && bus.m_ready && !rst;
        last_acc = in_acc;
        if (rst) begin
            model_reset();
        end else begin
            exp_fd = 1'b0;
            if (out_acc) begin
                n_out++;
                outs.push_back(int'(bus.m_data));
                last_out = int'(bus.m_data);
                out_cyc  = cyc;
                if (bus.m_last) n_last++;
                if (exp_q.size() > 0) begin
                    exp_fd = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
            if (in_acc) begin
                if (in_idx == 0) begin
                    act_wa = sh_wa;
                    act_wb = (sh_mode == 1) ? (1 << WW) - sh_wa : sh_wb;
                end
                exp_q.push_back('{ref_blend(int'(bus.s_pix_a), int'(bus.s_pix_b), act_wa, act_wb),
                                  in_idx == FP - 1});
                in_idx  = (in_idx + 1) % FP;
                acc_cyc = cyc;
                n_in++;
            end
            if (cfg_load) begin
                sh_mode = int'(cfg_mode);
                sh_wa   = int'(cfg_wa);
                sh_wb   = int'(cfg_wb);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
        rst_prev = rst;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        cfg_load    = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic load_cfg(input logic mode, input logic [WW-1:0] wa, input logic [WW-1:0] wb);
        cfg_load = 1'b1;
        cfg_mode = mode;
        cfg_wa   = wa;
        cfg_wb   = wb;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.s_valid = 1'b1;
        bus.s_pix_a = a;
        bus.s_pix_b = b;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", 0, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_pix_a = '0;
        bus.s_pix_b = '0;
        bus.m_ready = 1'b1;
        model_reset();

        // Reset weights: 0xFF*0x80>>8 + 0x01*0x80>>8 = 0x7F, two-cycle latency
        do_reset(2);
        send_beat(8'hFF, 8'h01);
        drain();
        chk("t1_data", 32'(last_out), 32'h7F);
        chk("t1_latency", 32'(out_cyc - acc_cyc), 2);

        // Independent full weights overflow the output width
        do_reset(1);
        load_cfg(1'b0, 8'hFF, 8'hFF);
        send_beat(8'hFF, 8'hFF);
        drain();
`ifdef BLEND_SATURATE_EN
        chk("t2_data", 32'(last_out), 32'hFF);
`else
        chk("t2_data", 32'(last_out), 32'hFC);
`endif

        // Complementary mode: wa = 0 passes B, wa = 0xC0 splits 0x60 + 0x10
        do_reset(1);
        load_cfg(1'b1, 8'h00, 8'h55);
        send_beat(8'h10, 8'h33);
        drain();
        chk("t3_pass_b", 32'(last_out), 32'h33);
        do_reset(1);
        load_cfg(1'b1, 8'hC0, 8'h00);
        send_beat(8'h80, 8'h40);
        drain();
        chk("t3_compl", 32'(last_out), 32'h70);

        // Back-to-back frames with mid-frame and frame-start cfg loads
        do_reset(1);
        outs.delete();
        n_last = 0;
        n_fd = 0;
        n_sready_low = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfg_load    = (i == 1) || (i == 8);
            cfg_mode    = (i == 8);
            cfg_wa      = (i == 8) ? 8'hFF : 8'h40;
            cfg_wb      = (i == 8) ? 8'h00 : 8'h20;
            bus.s_valid = 1'b1;
            bus.s_pix_a = 8'h80;
            bus.s_pix_b = 8'h80;
            tick();
            chk("t4_accept", 32'(last_acc), 1);
        end
        cfg_load = 1'b0;
        drain();
        tick();
        tick();
        chk("t4_n_last", 32'(n_last), 2);
        chk("t4_n_frame_done", 32'(n_fd), 2);
        chk("t4_s_ready_low", 32'(n_sready_low), 0);
        chk("t4_beat4", 32'(outs[3]), 32'h80);
        chk("t4_beat5", 32'(outs[4]), 32'h30);
        chk("t4_beat9", 32'(outs[8]), 32'h30);
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_pix_a = 8'h80;
            bus.s_pix_b = 8'h80;
            tick();
        end
        drain();
        chk("t4_n_last_12", 32'(n_last), 3);
        chk("t4_beat12", 32'(outs[11]), 32'h30);

        // Random backpressure with continuous input and occasional cfg loads
        do_reset(1);
        n_in = 0;
        n_out = 0;
        for (int i = 0; i < 400; i++) begin
            bus.m_ready = (i >= 100 && i < 105) ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.s_valid = 1'b1;
            bus.s_pix_a = DW'($urandom);
            bus.s_pix_b = DW'($urandom);
            cfg_load    = ($urandom_range(0, 19) == 0);
            cfg_mode    = 1'($urandom);
            cfg_wa      = WW'($urandom);
            cfg_wb      = WW'($urandom);
            tick();
        end
        cfg_load = 1'b0;
        drain();
        chk("t5_in_eq_out", 32'(n_in), 32'(n_out));

        // Reset with two beats in flight flushes them and restarts the frame
        do_reset(1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_pix_a = DW'($urandom);
            bus.s_pix_b = DW'($urandom);
            tick();
        end
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        snap = n_last;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_pix_a = DW'($urandom);
            bus.s_pix_b = DW'($urandom);
            tick();
        end
        drain();
        chk("t6_no_early_last", 32'(n_last - snap), 0);
        send_beat(8'h22, 8'h44);
        drain();
        chk("t6_last_after_frame", 32'(n_last - snap), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/image_blend_stream.md
# image_blend_stream

Streaming two-image alpha blender: accepts one pixel pair (A, B) per beat and produces `(A*wa >> W_W) + (B*wb >> W_W)` on an output stream. It generalises the fixed 0x80/0x80 blend in width and weights, and adds a complementary-weight mode, valid/ready backpressure, per-frame pixel counting and optional saturation. It sits between the two pixel-memory readers and the output-image writer.

## Interface
- `DATA_W`, 8, pixel width
- `W_W`, 8, weight width; weights are fractions of 2^W_W
- `FRAME_PIXELS`, 90000, pixels per frame (≥2)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cfg_load` in 1: capture `cfg_mode`/`cfg_wa`/`cfg_wb` into shadow registers
- `cfg_mode` in 1: 0 = independent weights, 1 = complementary (wb = 2^W_W − wa)
- `cfg_wa`, `cfg_wb` in W_W: weights; `cfg_wb` is ignored when mode = 1
- `s_valid` in 1, `s_ready` out 1, `s_pix_a`, `s_pix_b` in DATA_W: input beat
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_W, `m_last` out 1: output beat; `m_last` marks the final pixel of a frame
- `frame_done` out 1: one-cycle pulse when the last beat of a frame is accepted downstream

## Operation
- Shadow config is written on any `cfg_load`. It commits to the active weights only when an input beat is accepted while the input pixel counter is 0. One weight set is used for the whole frame.
- Active weights are W_W+1 bits wide. Mode 1 with wa = 0 gives wb = 2^W_W, i.e. B passes through unchanged.
- Lane product: `(pix * w) >> W_W`, computed full width (DATA_W+W_W+1 bits), then truncated. Sum of two lanes is DATA_W+1 bits.
- Output: low DATA_W bits of the sum, or saturated (see Configuration).
- Input counter: 0..FRAME_PIXELS−1, increments per accepted input beat, wraps to 0.
- Output counter: same range, increments per accepted output beat. `m_last` = (output counter == FRAME_PIXELS−1) while `m_valid` is high.
- `frame_done` pulses on the cycle after the `m_last` handshake; the output counter wraps to 0 in the same cycle.
- `cfg_load` coincident with a counter-0 acceptance: the commit uses the old shadow value; the new value applies from the next frame.

## Timing
- Two-stage pipeline: S1 registers both lane products, S2 registers the sum. Latency is 2 cycles from input accept to `m_valid`.
- Advance condition: `adv = !v2 || m_ready`. S1→S2 and input→S1 move only on `adv`.
- `s_ready = adv`, combinational from `m_ready`. Throughput is 1 beat/cycle with no bubbles.
- `m_valid`/`m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- Reset values: `m_valid` 0, `m_data` 0, `m_last` 0, `frame_done` 0, both counters 0, pipeline valids 0. Active and shadow config reset to mode 1, wa = wb = 2^(W_W−1). `s_ready` is 1 after reset.
- Reset mid-frame flushes in-flight beats. The next accepted beat is pixel 0 and commits the current shadow (reset value unless `cfg_load` followed).

## Configuration
- `BLEND_SATURATE_EN` defined: a sum above 2^DATA_W−1 clamps to 2^DATA_W−1.
- `BLEND_SATURATE_EN` undefined: the sum wraps modulo 2^DATA_W (legacy r1+r2 behaviour).

## Structure
- Shared package `blend_pkg`:
  - mode encoding constants `BLEND_MODE_INDEP`, `BLEND_MODE_COMPL`
  - reset-weight constant
  - product-width function
- Sub-module `blend_lane` (DATA_W, W_W): registered `(pix*w)>>W_W` with enable; instantiated twice. The multiplier inside stays swappable for the approximate multiplier variants.

## Test plan
- Reset, no cfg, input a = 0xFF, b = 0x01 → `m_data` 0x7F two cycles after accept; `s_ready` = 1 and `m_valid` = 0 during reset.
- Mode 0, wa = wb = 0xFF, a = b = 0xFF → 0xFF with `BLEND_SATURATE_EN`, 0xFC without.
- Mode 1, wa = 0, a = 0x10, b = 0x33 → 0x33; wa = 0xC0, a = 0x80, b = 0x40 → 0x60 + 0x10 = 0x70.
- FRAME_PIXELS = 4, 9 back-to-back beats → `m_last` on beats 4 and 8, `frame_done` pulses 2×, counter back to 1 after beat 9; a `cfg_load` mid-frame takes effect only at beat 5.
- Random `m_ready` (low 5 consecutive cycles included) with continuous `s_valid` → output sequence equals the reference model, no drop or duplicate, outputs stable while stalled.
- Assert `rst` one cycle with 2 beats in flight → `m_valid` 0 next cycle; the following beat carries `m_last` only after FRAME_PIXELS new beats.
